decode_imm_stage: RTL and testbench

//  IF/ID decode register: accepts 32-bit fetched instructions via valid/ready, splits fields, and

---
 rtl/decode_imm_stage_if.sv | 76 +++++++
 rtl/decode_imm_stage.sv | 212 +++++++++++++++++++++
 tb/tb_decode_imm_stage.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_imm_stage_if.sv
// ---------------------------------------------------------------------------
// decode_imm_stage_if
//   Handshake and data bundle for the IF/ID decode register.
//   The fetch-side channel (in_*) carries the raw instruction and its PC.
//   The decode-side channel (out_*) carries the split fields, the raw
//   immediate and its width selector.
//
//   Modports
//     master : environment view (drives in_valid/in_instr/in_pc/out_ready)
//     slave  : stage view       (drives in_ready and every out_* signal)
//
//   Optional feature macro: DECODE_ILLEGAL_EN adds out_ilegal.
//
//   Signals
//     in_valid    fetch presents in_instr/in_pc
//     in_ready    stage can accept this cycle (registered)
//     in_instr    32-bit instruction word
//     in_pc       PC of in_instr
//     out_valid   decoded instruction available
//     out_ready   downstream accepts
//     out_opcode  instr[31:28] (or the substitute opcode for illegal words)
//     out_rd      destination register, 0 when the format has none
//     out_rs1     source register 1, 0 when the format has none
//     out_rs2     instr[3:0] for opcode 0, else 0
//     out_func    instr[19:17] for the 17-bit format, else 0
//     out_entrada raw immediate, zero-padded above the field width
//     out_tipo    immediate width: 00=17b 01=20b 10=24b 11=28b
//     out_pc      PC of the presented instruction
//     out_ilegal  entry was an illegal opcode (DECODE_ILLEGAL_EN only)
// ---------------------------------------------------------------------------
interface decode_imm_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_opcode;
    logic [3:0]      out_rd;
    logic [3:0]      out_rs1;
    logic [3:0]      out_rs2;
    logic [2:0]      out_func;
    logic [27:0]     out_entrada;
    logic [1:0]      out_tipo;
    logic [PC_W-1:0] out_pc;

`ifdef DECODE_ILLEGAL_EN
    logic            out_ilegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
               out_func, out_entrada, out_tipo, out_pc, out_ilegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
               out_func, out_entrada, out_tipo, out_pc, out_ilegal
    );
`else
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
               out_func, out_entrada, out_tipo, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
               out_func, out_entrada, out_tipo, out_pc
    );
`endif
endinterface

// File: rtl/decode_imm_stage.sv
// ---------------------------------------------------------------------------
// decode_imm_stage
//   IF/ID decode register. Accepts 32-bit fetched instructions over a
//   valid/ready handshake, splits them into register fields, and produces
//   the raw immediate (entrada) plus its width selector (tipo) for the
//   combinational sign extender further down the pipe.
//
//   A two-entry skid buffer (main register + skid register) gives full
//   throughput while keeping in_ready a pure flop output.
//
//   Optional feature macro: DECODE_ILLEGAL_EN
//     When defined, opcode 0xF is illegal: the entry is replaced by a NOP
//     (opcode NOP_OP, all other fields 0, PC kept) and out_ilegal is raised
//     alongside it. When undefined, 0xF decodes as an ordinary 28-bit
//     immediate format and out_ilegal does not exist.
//
//   Parameters
//     PC_W    width of the PC carried with each instruction
//     NOP_OP  opcode substituted for illegal instructions
//
//   Ports
//     clk      rising-edge clock for all state
//     reset_n  synchronous reset, active low
//     flush    discard every held and incoming instruction
//     bus      decode_imm_stage_if.slave (fetch and decode channels)
// ---------------------------------------------------------------------------
module decode_imm_stage #(
    parameter int         PC_W   = 32,
    parameter logic [3:0] NOP_OP = 4'h0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    decode_imm_stage_if.slave bus
);

    // Immediate width selector; the encoding is what the sign extender expects.
    typedef enum logic [1:0] {
        TIPO_17 = 2'b00,
        TIPO_20 = 2'b01,
        TIPO_24 = 2'b10,
        TIPO_28 = 2'b11
    } tipo_e;

    // One fully decoded instruction as it sits in either buffer register.
    typedef struct packed {
        logic [3:0]      opcode;
        logic [3:0]      rd;
        logic [3:0]      rs1;
        logic [3:0]      rs2;
        logic [2:0]      func;
        logic [27:0]     entrada;
        tipo_e           tipo;
`ifdef DECODE_ILLEGAL_EN
        logic            ilegal;
`endif
        logic [PC_W-1:0] pc;
    } entry_t;

    logic [3:0] instrOp;
    entry_t     incoming;

    logic       mainValid_q, mainValid_d;
    logic       skidValid_q, skidValid_d;
    logic       inReady_q,   inReady_d;
    entry_t     mainEntry_q, mainEntry_d;
    entry_t     skidEntry_q, skidEntry_d;

    logic       inFire;
    logic       outFire;

    assign instrOp = bus.in_instr[31:28];

    // Decode the incoming word before it is registered, so both buffer
    // registers hold finished fields and the outputs come straight from flops.
    // The opcode's top bits select the immediate width: 0-7 -> 17b,
    // 8-B -> 20b, C-D -> 24b, E-F -> 28b. Fields a format does not use are
    // forced to zero so downstream never sees immediate bits as registers.
    always_comb begin
        incoming        = '0;
        incoming.pc     = bus.in_pc;
        incoming.opcode = instrOp;

        if (!instrOp[3]) begin
            incoming.tipo = TIPO_17;
        end else if (!instrOp[2]) begin
            incoming.tipo = TIPO_20;
        end else if (!instrOp[1]) begin
            incoming.tipo = TIPO_24;
        end else begin
            incoming.tipo = TIPO_28;
        end

        case (incoming.tipo)
            TIPO_17: begin
                incoming.rd      = bus.in_instr[27:24];
                incoming.rs1     = bus.in_instr[23:20];
                incoming.func    = bus.in_instr[19:17];
                incoming.entrada = {11'b0, bus.in_instr[16:0]};
            end
            TIPO_20: begin
                incoming.rd      = bus.in_instr[27:24];
                incoming.rs1     = bus.in_instr[23:20];
                incoming.entrada = {8'b0, bus.in_instr[19:0]};
            end
            TIPO_24: begin
                incoming.rd      = bus.in_instr[27:24];
                incoming.entrada = {4'b0, bus.in_instr[23:0]};
            end
            TIPO_28: begin
                incoming.entrada = bus.in_instr[27:0];
            end
        endcase

        // Only the register-register opcode carries a second source.
        if (instrOp == 4'h0) begin
            incoming.rs2 = bus.in_instr[3:0];
        end

`ifdef DECODE_ILLEGAL_EN
        // An illegal word travels on as a harmless NOP that still carries
        // its PC, so the exception logic downstream knows where it came from.
        if (instrOp == 4'hF) begin
            incoming        = '0;
            incoming.opcode = NOP_OP;
            incoming.ilegal = 1'b1;
            incoming.pc     = bus.in_pc;
        end
`endif
    end

    assign inFire  = bus.in_valid & inReady_q;
    assign outFire = mainValid_q & bus.out_ready;

    // Buffer control. The main register feeds the outputs; the skid register
    // only fills when a word was accepted while the main register was full
    // and stalled. Whenever the main register frees up, the skid entry moves
    // in ahead of any new word so strict FIFO order is preserved. Because
    // in_ready is registered as "skid empty", a full skid always blocks new
    // accepts on the following cycle. flush empties both entries and wins
    // over everything except reset.
    always_comb begin
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;
        mainEntry_d = mainEntry_q;
        skidEntry_d = skidEntry_q;

        if (flush) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
`ifdef DECODE_ILLEGAL_EN
            mainEntry_d.ilegal = 1'b0;
            skidEntry_d.ilegal = 1'b0;
`endif
        end else if (!mainValid_q || outFire) begin
            if (skidValid_q) begin
                mainValid_d = 1'b1;
                mainEntry_d = skidEntry_q;
                skidValid_d = inFire;
                if (inFire) begin
                    skidEntry_d = incoming;
                end
            end else begin
                mainValid_d = inFire;
                if (inFire) begin
                    mainEntry_d = incoming;
                end
            end
        end else if (inFire) begin
            skidValid_d = 1'b1;
            skidEntry_d = incoming;
        end

        inReady_d = !skidValid_d;
    end

    // State registers. in_ready clears in reset and only rises on the first
    // edge after reset is released, so fetch never sees a ready stage while
    // reset is still being applied.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            inReady_q   <= 1'b0;
            mainEntry_q <= '0;
            skidEntry_q <= '0;
        end else begin
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            inReady_q   <= inReady_d;
            mainEntry_q <= mainEntry_d;
            skidEntry_q <= skidEntry_d;
        end
    end

    // Every output is a direct flop output; nothing combinational reaches
    // the downstream stage or the fetch ready line.
    assign bus.in_ready    = inReady_q;
    assign bus.out_valid   = mainValid_q;
    assign bus.out_opcode  = mainEntry_q.opcode;
    assign bus.out_rd      = mainEntry_q.rd;
    assign bus.out_rs1     = mainEntry_q.rs1;
    assign bus.out_rs2     = mainEntry_q.rs2;
    assign bus.out_func    = mainEntry_q.func;
    assign bus.out_entrada = mainEntry_q.entrada;
    assign bus.out_tipo    = mainEntry_q.tipo;
    assign bus.out_pc      = mainEntry_q.pc;
`ifdef DECODE_ILLEGAL_EN
    assign bus.out_ilegal  = mainEntry_q.ilegal;
`endif

endmodule

// File: tb/tb_decode_imm_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_imm_stage
//   Self-checking bench for decode_imm_stage. A queue-based reference model
//   (at most two entries held, one cycle latency) predicts in_ready,
//   out_valid and the presented payload every cycle; fixed vectors with
//   hand-computed fields and a few directed sequences cover the corners.
//   Honours DECODE_ILLEGAL_EN when defined.
// ---------------------------------------------------------------------------
module tb_decode_imm_stage;

    localparam int         PC_W   = 32;
    localparam logic [3:0] NOP_OP = 4'h0;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;

    decode_imm_stage_if #(.PC_W(PC_W)) bus ();

    decode_imm_stage #(
        .PC_W   (PC_W),
        .NOP_OP (NOP_OP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [2:0]  func;
        logic [27:0] entrada;
        logic [1:0]  tipo;
        logic        ilegal;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        exp_t        want;
    } vec_t;

    int          testsRun    = 0;
    int          testsFailed = 0;
    string       phase       = "init";
    exp_t        modelQ[$];
    bit          justReset   = 1'b1;
    vec_t        tbl[$];
    logic [31:0] streamWord[8];
    logic [31:0] emitPc[$];
    int          idx;
    int          lastEmit;
    bit          ordy;
    bit          vld;
    bit          acc;
    bit          pending;
    bit          rVld;
    bit          rFl;
    logic [31:0] rInstr;
    logic [31:0] rPc;

    // Reference decode straight from the format rules, using plain arithmetic.
    function automatic exp_t refDecode(input logic [31:0] instr, input logic [31:0] pc);
        exp_t        r;
        int unsigned w;
        int unsigned op;
        int unsigned width;
        r     = '0;
        r.pc  = pc;
        w     = instr;
        op    = w >> 28;
`ifdef DECODE_ILLEGAL_EN
        if (op == 15) begin
            r.opcode = NOP_OP;
            r.ilegal = 1'b1;
            return r;
        end
`endif
        r.opcode = 4'(op);
        if (op < 8) begin
            r.tipo = 2'd0; width = 17;
        end else if (op < 12) begin
            r.tipo = 2'd1; width = 20;
        end else if (op < 14) begin
            r.tipo = 2'd2; width = 24;
        end else begin
            r.tipo = 2'd3; width = 28;
        end
        r.entrada = 28'(w % (32'd1 << width));
        if (width != 28) r.rd   = 4'((w >> 24) % 16);
        if (width < 24)  r.rs1  = 4'((w >> 20) % 16);
        if (width == 17) r.func = 3'((w >> 17) % 8);
        if (op == 0)     r.rs2  = 4'(w % 16);
        return r;
    endfunction

    function automatic exp_t mkExp(input logic [3:0] op, input logic [3:0] rd,
                                   input logic [3:0] rs1, input logic [3:0] rs2,
                                   input logic [2:0] func, input logic [27:0] ent,
                                   input logic [1:0] tipo, input logic ileg,
                                   input logic [31:0] pc);
        exp_t r;
        r = '{op, rd, rs1, rs2, func, ent, tipo, ileg, pc};
        return r;
    endfunction

    function automatic exp_t dutPayload();
        exp_t r;
        r.opcode  = bus.out_opcode;
        r.rd      = bus.out_rd;
        r.rs1     = bus.out_rs1;
        r.rs2     = bus.out_rs2;
        r.func    = bus.out_func;
        r.entrada = bus.out_entrada;
        r.tipo    = bus.out_tipo;
`ifdef DECODE_ILLEGAL_EN
        r.ilegal  = bus.out_ilegal;
`else
        r.ilegal  = 1'b0;
`endif
        r.pc      = bus.out_pc;
        return r;
    endfunction

    function automatic bit modelInReady();
        return !justReset && (modelQ.size() < 2);
    endfunction

    task automatic addVec(input logic [31:0] instr, input logic [31:0] pc, input exp_t want);
        vec_t v;
        v.instr = instr;
        v.pc    = pc;
        v.want  = want;
        tbl.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s/%s: got %0h, required %0h", phase, name, act, req);
        end
    endtask

    // Drive one cycle: compare the DUT against the model, clock, update the model.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic ordyIn, input logic fl);
        bit inFire;
        bit outFire;
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = ordyIn;
        flush         = fl;
        checkOutput("in_ready", 128'(bus.in_ready), 128'(modelInReady()));
        checkOutput("out_valid", 128'(bus.out_valid), 128'(modelQ.size() > 0));
        if (modelQ.size() > 0) begin
            checkOutput("payload", 128'(dutPayload()), 128'(modelQ[0]));
        end
        inFire  = v && modelInReady();
        outFire = ordyIn && (modelQ.size() > 0);
        @(posedge clk);
        if (!reset_n) begin
            modelQ.delete();
            justReset = 1'b1;
        end else begin
            justReset = 1'b0;
            if (fl) begin
                modelQ.delete();
            end else begin
                if (outFire) void'(modelQ.pop_front());
                if (inFire)  modelQ.push_back(refDecode(instr, pc));
            end
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        phase         = "reset";
        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        justReset = 1'b1;
        applyStimulus(0, 32'h0, 32'h0, 0, 0);
        checkOutput("rst_pc", 128'(bus.out_pc), 128'(0));
        checkOutput("rst_entrada", 128'(bus.out_entrada), 128'(0));
        checkOutput("rst_opcode", 128'(bus.out_opcode), 128'(0));
        reset_n = 1'b1;
        applyStimulus(0, 32'h0, 32'h0, 1, 0);
        checkOutput("in_ready_after_release", 128'(bus.in_ready), 128'(1));

        // ---------------- fixed vectors ----------------
        phase = "vectors";
        addVec(32'h3A52ABCD, 32'h100, mkExp(4'h3, 4'hA, 4'h5, 4'h0, 3'd1, 28'h000ABCD, 2'd0, 1'b0, 32'h100));
        addVec(32'hE8000001, 32'h104, mkExp(4'hE, 4'h0, 4'h0, 4'h0, 3'd0, 28'h8000001, 2'd3, 1'b0, 32'h104));
        addVec(32'hC1FFFFFF, 32'h108, mkExp(4'hC, 4'h1, 4'h0, 4'h0, 3'd0, 28'h0FFFFFF, 2'd2, 1'b0, 32'h108));
        addVec(32'h01234567, 32'h10C, mkExp(4'h0, 4'h1, 4'h2, 4'h7, 3'd1, 28'h0014567, 2'd0, 1'b0, 32'h10C));
        addVec(32'h9ABCDEF0, 32'h110, mkExp(4'h9, 4'hA, 4'hB, 4'h0, 3'd0, 28'h00CDEF0, 2'd1, 1'b0, 32'h110));
        addVec(32'hD1234567, 32'h114, mkExp(4'hD, 4'h1, 4'h0, 4'h0, 3'd0, 28'h0234567, 2'd2, 1'b0, 32'h114));
        addVec(32'h7FFFFFFF, 32'h118, mkExp(4'h7, 4'hF, 4'hF, 4'h0, 3'd7, 28'h001FFFF, 2'd0, 1'b0, 32'h118));
        addVec(32'hBFFFFFFF, 32'h11C, mkExp(4'hB, 4'hF, 4'hF, 4'h0, 3'd0, 28'h00FFFFF, 2'd1, 1'b0, 32'h11C));
        addVec(32'h80000000, 32'h120, mkExp(4'h8, 4'h0, 4'h0, 4'h0, 3'd0, 28'h0000000, 2'd1, 1'b0, 32'h120));
`ifdef DECODE_ILLEGAL_EN
        addVec(32'hF0000000, 32'h40, mkExp(NOP_OP, 4'h0, 4'h0, 4'h0, 3'd0, 28'h0, 2'd0, 1'b1, 32'h40));
`else
        addVec(32'hF0000000, 32'h40, mkExp(4'hF, 4'h0, 4'h0, 4'h0, 3'd0, 28'h0, 2'd3, 1'b0, 32'h40));
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(1, tbl[i].instr, tbl[i].pc, 1, 0);
            checkOutput($sformatf("vec%0d_valid", i), 128'(bus.out_valid), 128'(1));
            checkOutput($sformatf("vec%0d_fields", i), 128'(dutPayload()), 128'(tbl[i].want));
        end
        applyStimulus(0, 32'h0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);

        // ---------------- stream of 8 with a 3-cycle stall ----------------
        phase = "stream";
        for (int i = 0; i < 8; i++) streamWord[i] = $urandom;
        idx      = 0;
        lastEmit = -1;
        for (int c = 0; c < 14; c++) begin
            ordy = !(c >= 3 && c <= 5);
            vld  = (idx < 8);
            acc  = vld && modelInReady();
            if (c == 4) checkOutput("in_ready_low_two_held", 128'(bus.in_ready), 128'(0));
            if (bus.out_valid && ordy) begin
                emitPc.push_back(bus.out_pc);
                lastEmit = c;
            end
            applyStimulus(vld, (idx < 8) ? streamWord[idx] : 32'h0, 32'h200 + 32'(4 * idx), ordy, 0);
            if (acc) idx++;
        end
        checkOutput("stream_count", 128'(emitPc.size()), 128'(8));
        checkOutput("stream_last_cycle", 128'(lastEmit), 128'(11));
        for (int i = 0; i < emitPc.size(); i++) begin
            checkOutput($sformatf("stream_order%0d", i), 128'(emitPc[i]), 128'(32'h200 + 32'(4 * i)));
        end

        // ---------------- flush with both entries full ----------------
        phase = "flush";
        applyStimulus(1, 32'h11111111, 32'h300, 0, 0);
        applyStimulus(1, 32'h22222222, 32'h304, 0, 0);
        checkOutput("full_in_ready", 128'(bus.in_ready), 128'(0));
        applyStimulus(1, 32'h33333333, 32'h308, 1, 1);
        checkOutput("flushed_valid", 128'(bus.out_valid), 128'(0));
        checkOutput("flushed_in_ready", 128'(bus.in_ready), 128'(1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h0, 32'h0, 1, 0);
            checkOutput($sformatf("no_emit%0d", i), 128'(bus.out_valid), 128'(0));
        end
        applyStimulus(1, 32'h44444444, 32'h30C, 1, 1);
        checkOutput("accept_in_flush_dropped", 128'(bus.out_valid), 128'(0));

        // ---------------- reset mid-transfer (flush also high) ----------------
        phase = "midreset";
        applyStimulus(1, 32'h55555555, 32'h400, 0, 0);
        applyStimulus(1, 32'h66666666, 32'h404, 0, 0);
        reset_n = 1'b0;
        applyStimulus(1, 32'h77777777, 32'h408, 1, 1);
        checkOutput("rst_valid", 128'(bus.out_valid), 128'(0));
        checkOutput("rst_in_ready", 128'(bus.in_ready), 128'(0));
        checkOutput("rst_pc", 128'(bus.out_pc), 128'(0));
        reset_n = 1'b1;
        applyStimulus(0, 32'h0, 32'h0, 1, 0);
        checkOutput("in_ready_after_release", 128'(bus.in_ready), 128'(1));

        // ---------------- randomized traffic ----------------
        phase   = "random";
        pending = 1'b0;
        rVld    = 1'b0;
        rInstr  = '0;
        rPc     = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pending) begin
                rVld   = ($urandom_range(3) != 0);
                rInstr = $urandom;
                rPc    = $urandom;
            end
            rFl  = ($urandom_range(15) == 0);
            ordy = ($urandom_range(2) != 0);
            acc  = rVld && modelInReady();
            applyStimulus(rVld, rInstr, rPc, ordy, rFl);
            pending = rVld && !acc;
        end
        applyStimulus(0, 32'h0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
